// File: rtl/sgmii_rx_frame_buf.sv
// SGMII RX byte stream to GMII: K-code framing, 10/100 decimation, whole-frame FIFO replay.
// Optional statistics outputs are enabled by defining SGMII_RX_STATS_EN.
module sgmii_rx_frame_buf #(
  parameter int unsigned DEPTH_LOG2 = 11,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_125mhz,
  input  logic             rst_n,
  input  logic             sgmii_autoneg_done,
  input  logic [1:0]       rx_speed,
  input  logic             rx_vld,
  input  logic [7:0]       rx_byte,
  input  logic             rx_is_k,
  output logic [7:0]       gmii_rxd,
  output logic             gmii_rx_dv,
  output logic             gmii_rx_err,
  output logic             frame_drop
`ifdef SGMII_RX_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_errors,
  output logic [CNT_W-1:0] stat_drops
`endif
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned ENT_W = 10;
  localparam int unsigned REP_W = 7;
  localparam logic [7:0]  K_IDLE = 8'hBC;
  localparam logic [7:0]  K_SOP  = 8'hFB;
  localparam logic [7:0]  K_EOP  = 8'hFD;
  localparam logic [7:0]  K_ERR  = 8'hFE;

  typedef enum logic [1:0] {IN_IDLE, IN_PKT, IN_DROP} in_state_t;
  typedef enum logic {O_IDLE, O_BUSY} out_state_t;

  in_state_t            in_state, in_state_n;
  out_state_t           out_state, out_state_n;
  logic [PTR_W-1:0]     wr_ptr, wr_ptr_n, wr_start, wr_start_n, rd_ptr, frm_cnt;
  logic                 hold_vld, hold_vld_n, err_flag, err_flag_n;
  logic [7:0]           hold_byte, hold_byte_n;
  logic [REP_W-1:0]     rep_cnt, rep_cnt_n, rep_max, rep_max_n;
  logic                 push_c, push_last_c, full_c;
  logic                 wr_en_c, commit_c, drop_c, pop_c, pop_last_c;
  logic [ENT_W-1:0]     wr_data_c, rd_entry;
  logic [ENT_W-1:0]     mem [DEPTH];

  assign full_c   = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
  assign rd_entry = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Input side: framing, decimation, holdback and commit/drop of frames.
  always_comb begin
    in_state_n  = in_state;
    wr_ptr_n    = wr_ptr;
    wr_start_n  = wr_start;
    hold_vld_n  = hold_vld;
    hold_byte_n = hold_byte;
    err_flag_n  = err_flag;
    rep_cnt_n   = rep_cnt;
    rep_max_n   = rep_max;
    push_c      = 1'b0;
    push_last_c = 1'b0;
    wr_en_c     = 1'b0;
    wr_data_c   = '0;
    commit_c    = 1'b0;
    drop_c      = 1'b0;
    if (!sgmii_autoneg_done) begin
      wr_ptr_n   = wr_start;
      hold_vld_n = 1'b0;
      in_state_n = IN_IDLE;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (rx_vld && rx_is_k && rx_byte == K_SOP) begin
            rep_max_n  = rx_speed[1] ? REP_W'(0) : (rx_speed[0] ? REP_W'(9) : REP_W'(99));
            rep_cnt_n  = '0;
            err_flag_n = 1'b0;
            hold_vld_n = 1'b0;
            in_state_n = IN_PKT;
          end
        end
        IN_PKT: begin
          if (rx_vld && !rx_is_k) begin
            if (rep_cnt == '0) begin
              push_c      = hold_vld;
              wr_data_c   = {err_flag, 1'b0, hold_byte};
              hold_byte_n = rx_byte;
              hold_vld_n  = 1'b1;
            end
            rep_cnt_n = (rep_cnt == rep_max) ? '0 : rep_cnt + REP_W'(1);
          end else if (rx_vld && rx_byte == K_ERR) begin
            err_flag_n = 1'b1;
          end else if (rx_vld && (rx_byte == K_EOP || rx_byte == K_IDLE || rx_byte == K_SOP)) begin
            // Anything but EOP closing the frame is a truncation.
            push_c      = hold_vld;
            push_last_c = 1'b1;
            wr_data_c   = {(rx_byte == K_EOP) ? err_flag : 1'b1, 1'b1, hold_byte};
            hold_vld_n  = 1'b0;
            in_state_n  = IN_IDLE;
          end
        end
        IN_DROP: begin
          if (rx_vld && rx_is_k && (rx_byte == K_EOP || rx_byte == K_IDLE))
            in_state_n = IN_IDLE;
        end
        default: in_state_n = IN_IDLE;
      endcase
      if (push_c) begin
        if (full_c) begin
          wr_ptr_n   = wr_start;
          drop_c     = 1'b1;
          hold_vld_n = 1'b0;
          in_state_n = IN_DROP;
        end else begin
          wr_en_c  = 1'b1;
          wr_ptr_n = wr_ptr + PTR_W'(1);
          if (push_last_c) begin
            commit_c   = 1'b1;
            wr_start_n = wr_ptr + PTR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      in_state   <= IN_IDLE;
      wr_ptr     <= '0;
      wr_start   <= '0;
      hold_vld   <= 1'b0;
      hold_byte  <= '0;
      err_flag   <= 1'b0;
      rep_cnt    <= '0;
      rep_max    <= '0;
      frame_drop <= 1'b0;
    end else begin
      in_state   <= in_state_n;
      wr_ptr     <= wr_ptr_n;
      wr_start   <= wr_start_n;
      hold_vld   <= hold_vld_n;
      hold_byte  <= hold_byte_n;
      err_flag   <= err_flag_n;
      rep_cnt    <= rep_cnt_n;
      rep_max    <= rep_max_n;
      frame_drop <= drop_c;
    end
  end

  always_ff @(posedge clk_125mhz) begin
    if (wr_en_c) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data_c;
  end

  // Output side: replay one committed frame at a time with contiguous dv.
  always_comb begin
    out_state_n = out_state;
    pop_c       = 1'b0;
    pop_last_c  = 1'b0;
    case (out_state)
      O_IDLE: if (frm_cnt != '0) out_state_n = O_BUSY;
      O_BUSY: begin
        pop_c = 1'b1;
        if (rd_entry[8]) begin
          pop_last_c  = 1'b1;
          out_state_n = O_IDLE;
        end
      end
      default: out_state_n = O_IDLE;
    endcase
  end

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      out_state   <= O_IDLE;
      rd_ptr      <= '0;
      frm_cnt     <= '0;
      gmii_rxd    <= '0;
      gmii_rx_dv  <= 1'b0;
      gmii_rx_err <= 1'b0;
    end else begin
      out_state   <= out_state_n;
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      frm_cnt     <= frm_cnt + PTR_W'(commit_c) - PTR_W'(pop_last_c);
      gmii_rx_dv  <= pop_c;
      gmii_rxd    <= pop_c ? rd_entry[7:0] : 8'h00;
      gmii_rx_err <= pop_c & rd_entry[9];
    end
  end

`ifdef SGMII_RX_STATS_EN
  // Saturating statistics; cleared only by reset.
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_errors <= '0;
      stat_drops  <= '0;
    end else begin
      if (commit_c && stat_frames != '1) stat_frames <= stat_frames + CNT_W'(1);
      if (commit_c && wr_data_c[9] && stat_errors != '1) stat_errors <= stat_errors + CNT_W'(1);
      if (drop_c && stat_drops != '1) stat_drops <= stat_drops + CNT_W'(1);
    end
  end
`endif

endmodule
